// File: rtl/cpu_pkg.sv
// Shared CPU package: the fetch-state encoding, the bus width defaults used by the
// fetch unit, datapath and decoder, and the program counter reset value.
package cpu_pkg;

    localparam int CPU_ADDR_W   = 8;
    localparam int CPU_DATA_W   = 16;
    localparam int CPU_RESET_PC = 0;

    // Encoding is visible on the LEDs through fstate, so the values are fixed.
    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_ISSUE = 2'd1,
        FS_WAIT  = 2'd2,
        FS_VALID = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory read bus between the fetch unit (master) and instruction
// memory (slave): one-cycle read strobe with address, data returned with a valid.
interface fetch_unit_if #(
    parameter int ADDR_W = cpu_pkg::CPU_ADDR_W,
    parameter int DATA_W = cpu_pkg::CPU_DATA_W
);
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;

    modport master (
        output rd,
        output addr,
        input  rdata,
        input  rvalid
    );

    modport slave (
        input  rd,
        input  addr,
        output rdata,
        output rvalid
    );
endinterface

// File: rtl/fetch_timer.sv
// Fetch WAIT-state timeout timer. Only instantiated when FETCH_TIMEOUT_EN is defined.
// Down-counter reloaded while the read is issued, so it restarts on every entry to
// WAIT; expired is raised on the TIMEOUT-th consecutive WAIT cycle.
module fetch_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic run,
    output logic expired
);
    localparam int             CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Reload on issue, count down while waiting, park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = LOAD;
        end else if (run && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = run && (cnt_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-word reads to instruction
// memory and holds the returned word in the instruction register until the
// controller acknowledges it. A pc_load redirect is accepted in every state.
// Optional feature macro: FETCH_TIMEOUT_EN (abort a read stuck in WAIT and set
// the sticky fault flag; without it WAIT lasts until data returns, fault is 0).
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | nothing in flight, waiting for fetch_req
// ISSUE    | mem_rd high for this single cycle, mem_addr = PC of the read
// WAIT     | read outstanding, waiting for mem_rvalid (or squashed/timeout)
// VALID    | instr holds an unconsumed word, waiting for instr_ack
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = CPU_ADDR_W,
    parameter int DATA_W   = CPU_DATA_W,
    parameter int RESET_PC = CPU_RESET_PC,
    parameter int TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic              instr_ack,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_target,
    fetch_unit_if.master      mem_bus,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              fault,
    output logic [1:0]        fstate
);
    localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              instr_valid_q, instr_valid_d;
    logic              mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              squash_q, squash_d;
    logic              fault_q, fault_d;
    logic              wait_expired;

`ifdef FETCH_TIMEOUT_EN
    logic timer_start;
    logic timer_run;

    assign timer_start = (state_q == FS_ISSUE);
    assign timer_run   = (state_q == FS_WAIT);

    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_fetch_timer (
        .clk     (clk),
        .reset   (reset),
        .start   (timer_start),
        .run     (timer_run),
        .expired (wait_expired)
    );
`else
    localparam int timeout_unused = TIMEOUT;
    assign wait_expired = 1'b0;
`endif

    // Next-state and next-output logic; pc_load overrides the PC last so it wins
    // over the post-fetch increment in every state.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        mem_rd_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        squash_d      = squash_q;
        fault_d       = fault_q;

        case (state_q)
            FS_IDLE: begin
                if (fetch_req) begin
                    state_d  = FS_ISSUE;
                    // A redirect in the same cycle still issues at the old PC,
                    // so that read's data must be thrown away.
                    squash_d = pc_load;
                end
            end
            FS_ISSUE: begin
                state_d = FS_WAIT;
                if (pc_load) begin
                    squash_d = 1'b1;
                end
            end
            FS_WAIT: begin
                if (mem_bus.rvalid) begin
                    squash_d = 1'b0;
                    if (squash_q || pc_load) begin
                        state_d = FS_IDLE;
                    end else begin
                        instr_d       = mem_bus.rdata;
                        pc_d          = pc_q + ADDR_W'(1);
                        instr_valid_d = 1'b1;
                        state_d       = FS_VALID;
                    end
                end else if (wait_expired) begin
                    squash_d = 1'b0;
                    fault_d  = 1'b1;
                    state_d  = FS_IDLE;
                end else if (pc_load) begin
                    squash_d = 1'b1;
                end
            end
            FS_VALID: begin
                if (pc_load) begin
                    instr_valid_d = 1'b0;
                    state_d       = FS_IDLE;
                end else if (instr_ack) begin
                    instr_valid_d = 1'b0;
                    squash_d      = 1'b0;
                    state_d       = fetch_req ? FS_ISSUE : FS_IDLE;
                end
            end
            default: begin
                state_d = FS_IDLE;
            end
        endcase

        if (pc_load) begin
            pc_d = pc_target;
        end

        // Strobe and address are launched from flops for the ISSUE cycle, using
        // the PC as it stands before any same-cycle redirect.
        if (state_d == FS_ISSUE) begin
            mem_rd_d   = 1'b1;
            mem_addr_d = pc_q;
        end
    end

    // State and output registers; reset abandons any read in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= FS_IDLE;
            pc_q          <= PC_RST;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            mem_rd_q      <= 1'b0;
            mem_addr_q    <= PC_RST;
            squash_q      <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            mem_rd_q      <= mem_rd_d;
            mem_addr_q    <= mem_addr_d;
            squash_q      <= squash_d;
            fault_q       <= fault_d;
        end
    end

    assign mem_bus.rd   = mem_rd_q;
    assign mem_bus.addr = mem_addr_q;
    assign instr        = instr_q;
    assign instr_valid  = instr_valid_q;
    assign pc           = pc_q;
    assign fault        = fault_q;
    assign fstate       = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized mix of
// fetches, redirects and acknowledges, checked against a transaction-level model
// (PC value, committed instruction, memory image and per-fetch cycle timeline).
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic        instr_ack;
    logic        pc_load;
    logic [7:0]  pc_target;
    logic [15:0] instr;
    logic        instr_valid;
    logic [7:0]  pc;
    logic        fault;
    logic [1:0]  fstate;

    fetch_unit_if #(.ADDR_W(8), .DATA_W(16)) mem_bus ();

    fetch_unit #(
        .ADDR_W   (8),
        .DATA_W   (16),
        .RESET_PC (0),
        .TIMEOUT  (15)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .instr_ack   (instr_ack),
        .pc_load     (pc_load),
        .pc_target   (pc_target),
        .mem_bus     (mem_bus),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .fault       (fault),
        .fstate      (fstate)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    logic [15:0] mem [256];
    logic [7:0]  model_pc;
    logic [15:0] model_instr;
    bit          in_valid;
    bit          model_fault;

    int          it_lat;
    int          it_sel;
    logic [7:0]  it_tgt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        fetch_req     = 1'b0;
        instr_ack     = 1'b0;
        pc_load       = 1'b0;
        mem_bus.rvalid = 1'b0;
        mem_bus.rdata  = 16'($urandom);
    endtask

    // One fetch whose start request the caller has already driven for cycle 0.
    // lat: cycles from mem_rd to mem_rvalid. ld_at: cycle of a pc_load redirect
    // (0 = with the request from IDLE, 1 = ISSUE, 2.. = WAIT), or -1 for none.
    task automatic fetch_txn(input int lat, input int ld_at, input logic [7:0] tgt);
        logic [7:0] a;
        logic [7:0] pc_exp;
        a = model_pc;
        if (ld_at == 0) begin
            pc_load   = 1'b1;
            pc_target = tgt;
        end
        for (int c = 1; c <= lat + 1; c++) begin
            tick();
            clear_inputs();
            if (c == ld_at) begin
                pc_load   = 1'b1;
                pc_target = tgt;
            end
            if (c == lat + 1) begin
                mem_bus.rvalid = 1'b1;
                mem_bus.rdata  = mem[a];
            end
            pc_exp = (ld_at >= 0 && c > ld_at) ? tgt : a;
            chk("mem_rd", mem_bus.rd, (c == 1));
            if (c == 1) chk("mem_addr", mem_bus.addr, a);
            chk("fstate_busy", fstate, (c == 1) ? 1 : 2);
            chk("ivalid_busy", instr_valid, 0);
            chk("pc_busy", pc, pc_exp);
        end
        tick();
        clear_inputs();
        if (ld_at >= 0) begin
            model_pc = tgt;
            in_valid = 1'b0;
            chk("sq_fstate", fstate, 0);
            chk("sq_ivalid", instr_valid, 0);
            chk("sq_instr", instr, model_instr);
            chk("sq_pc", pc, model_pc);
        end else begin
            model_pc    = a + 8'd1;
            model_instr = mem[a];
            in_valid    = 1'b1;
            chk("done_fstate", fstate, 3);
            chk("done_ivalid", instr_valid, 1);
            chk("done_instr", instr, model_instr);
            chk("done_pc", pc, model_pc);
        end
        chk("fault", fault, model_fault);
    endtask

    task automatic hold_valid(input int n);
        for (int i = 0; i < n; i++) begin
            mem_bus.rvalid = 1'($urandom);
            mem_bus.rdata  = 16'($urandom);
            tick();
            chk("hold_fstate", fstate, 3);
            chk("hold_ivalid", instr_valid, 1);
            chk("hold_instr", instr, model_instr);
            chk("hold_pc", pc, model_pc);
        end
        clear_inputs();
    endtask

    task automatic ack_only();
        instr_ack      = 1'b1;
        mem_bus.rvalid = 1'($urandom);
        tick();
        clear_inputs();
        in_valid = 1'b0;
        chk("ack_fstate", fstate, 0);
        chk("ack_ivalid", instr_valid, 0);
        chk("ack_instr", instr, model_instr);
        chk("ack_pc", pc, model_pc);
    endtask

    task automatic load_in_valid(input logic [7:0] tgt);
        pc_load   = 1'b1;
        pc_target = tgt;
        instr_ack = 1'($urandom);
        fetch_req = 1'($urandom);
        tick();
        clear_inputs();
        model_pc = tgt;
        in_valid = 1'b0;
        chk("vld_ld_fstate", fstate, 0);
        chk("vld_ld_ivalid", instr_valid, 0);
        chk("vld_ld_pc", pc, model_pc);
    endtask

    task automatic load_idle(input logic [7:0] tgt);
        pc_load        = 1'b1;
        pc_target      = tgt;
        mem_bus.rvalid = 1'($urandom);
        tick();
        clear_inputs();
        model_pc = tgt;
        chk("idle_ld_fstate", fstate, 0);
        chk("idle_ld_pc", pc, model_pc);
        chk("idle_ld_rd", mem_bus.rd, 0);
    endtask

    task automatic idle_wait(input int n);
        for (int i = 0; i < n; i++) begin
            mem_bus.rvalid = 1'($urandom);
            mem_bus.rdata  = 16'($urandom);
            tick();
            chk("idle_fstate", fstate, 0);
            chk("idle_ivalid", instr_valid, 0);
            chk("idle_rd", mem_bus.rd, 0);
            chk("idle_fault", fault, model_fault);
        end
        clear_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[0] = 16'hD105;
        pc_target = 8'h00;
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_pc    = 8'h00;
        model_instr = 16'h0000;
        in_valid    = 1'b0;
        model_fault = 1'b0;

        chk("rst_pc", pc, 8'h00);
        chk("rst_instr", instr, 16'h0000);
        chk("rst_ivalid", instr_valid, 0);
        chk("rst_rd", mem_bus.rd, 0);
        chk("rst_fault", fault, 0);
        chk("rst_fstate", fstate, 0);

        // First fetch, 1-cycle memory, then three back-to-back fetches.
        fetch_req = 1'b1;
        fetch_txn(1, -1, 8'h00);
        for (int i = 0; i < 3; i++) begin
            instr_ack = 1'b1;
            fetch_req = 1'b1;
            fetch_txn(1, -1, 8'h00);
        end
        hold_valid(2);
        ack_only();

        // PC wrap from 0xFF.
        load_idle(8'hFF);
        fetch_req = 1'b1;
        fetch_txn(2, -1, 8'h00);
        ack_only();

        // Branch on WAIT cycle 2 with 4-cycle memory.
        fetch_req = 1'b1;
        fetch_txn(4, 3, 8'h40);
        idle_wait(2);

        // Redirect in the same cycle as the returning data.
        fetch_req = 1'b1;
        fetch_txn(2, 3, 8'h22);

        // Redirects at request and in ISSUE.
        fetch_req = 1'b1;
        fetch_txn(1, 0, 8'h80);
        fetch_req = 1'b1;
        fetch_txn(3, 1, 8'h10);

        for (int it = 0; it < 60; it++) begin
            it_lat = $urandom_range(1, 5);
            it_sel = $urandom_range(0, 3);
            it_tgt = 8'($urandom);
            if (in_valid) begin
                case (it_sel)
                    0: ack_only();
                    1: begin
                        instr_ack = 1'b1;
                        fetch_req = 1'b1;
                        fetch_txn(it_lat, -1, 8'h00);
                    end
                    2: load_in_valid(it_tgt);
                    default: hold_valid($urandom_range(1, 3));
                endcase
            end else begin
                case (it_sel)
                    0: begin
                        fetch_req = 1'b1;
                        fetch_txn(it_lat, -1, 8'h00);
                    end
                    1: begin
                        idle_wait($urandom_range(1, 2));
                        fetch_req = 1'b1;
                        fetch_txn(it_lat, -1, 8'h00);
                    end
                    2: begin
                        fetch_req = 1'b1;
                        fetch_txn(it_lat, $urandom_range(0, it_lat + 1), it_tgt);
                    end
                    default: load_idle(it_tgt);
                endcase
            end
        end
        if (in_valid) ack_only();

`ifdef FETCH_TIMEOUT_EN
        // Memory never answers: abort after 15 WAIT cycles with a sticky fault.
        fetch_req = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            clear_inputs();
            chk("to_busy_fstate", fstate, (c == 1) ? 1 : 2);
            chk("to_busy_fault", fault, 0);
        end
        tick();
        model_fault = 1'b1;
        chk("to_fstate", fstate, 0);
        chk("to_fault", fault, 1);
        chk("to_pc", pc, model_pc);
        chk("to_instr", instr, model_instr);
        chk("to_ivalid", instr_valid, 0);
        idle_wait(3);
        fetch_req = 1'b1;
        fetch_txn(2, -1, 8'h00);
        ack_only();
`else
        // Without the timeout a slow memory is simply waited for.
        fetch_req = 1'b1;
        fetch_txn(20, -1, 8'h00);
        ack_only();
`endif

        // Asynchronous reset while a read is outstanding.
        load_idle(8'h5A);
        fetch_req = 1'b1;
        tick();
        clear_inputs();
        tick();
        chk("pre_rst_fstate", fstate, 2);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_pc", pc, 8'h00);
        chk("arst_ivalid", instr_valid, 0);
        chk("arst_instr", instr, 16'h0000);
        chk("arst_fstate", fstate, 0);
        chk("arst_rd", mem_bus.rd, 0);
        chk("arst_fault", fault, 0);
        #2;
        reset = 1'b0;
        model_pc    = 8'h00;
        model_instr = 16'h0000;
        model_fault = 1'b0;
        tick();
        mem_bus.rvalid = 1'b1;
        mem_bus.rdata  = 16'hBEEF;
        tick();
        clear_inputs();
        chk("late_rv_fstate", fstate, 0);
        chk("late_rv_ivalid", instr_valid, 0);
        chk("late_rv_instr", instr, model_instr);
        chk("late_rv_pc", pc, model_pc);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
